// File: rtl/ibex_lsu_resp_tracker_pkg.sv
// Shared types for the LSU response tracker: writeback instruction type,
// access size encoding and the per-request metadata kept in the queue.
package ibex_lsu_resp_tracker_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    wb_instr_type_e instr_type;
    lsu_size_e      size;
    logic           sign_ext;
    logic [1:0]     offset;
  } lsu_resp_meta_t;

endpackage

// File: rtl/ibex_lsu_rdata_fmt.sv
// Combinational load-data formatter: aligns the addressed byte lane to bit 0,
// then selects byte/halfword/word and applies sign or zero extension.
module ibex_lsu_rdata_fmt
  import ibex_lsu_resp_tracker_pkg::*;
(
  input  lsu_resp_meta_t meta_i,
  input  logic [31:0]    rdata_i,
  output logic [31:0]    rdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {meta_i.offset, 3'b000};

  always_comb begin
    rdata_o = rdata_i;
    unique case (meta_i.size)
      LSU_SIZE_B: rdata_o = {{24{meta_i.sign_ext & shifted[7]}}, shifted[7:0]};
      LSU_SIZE_H: rdata_o = {{16{meta_i.sign_ext & shifted[15]}}, shifted[15:0]};
      default:    rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_tracker.sv
// In-order tracker pairing data-bus responses with granted requests and
// producing the writeback-stage load/store completion signals.
module ibex_lsu_resp_tracker
  import ibex_lsu_resp_tracker_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,

  input  logic                               req_valid_i,
  input  wb_instr_type_e                     req_type_i,
  input  logic [1:0]                         req_size_i,
  input  logic                               req_sign_ext_i,
  input  logic [1:0]                         req_offset_i,
  output logic                               req_ready_o,

  input  logic                               data_rvalid_i,
  input  logic [31:0]                        data_rdata_i,
  input  logic                               data_err_i,

  output logic                               lsu_data_valid_o,
  output logic                               rf_we_lsu_o,
  output logic [31:0]                        rf_wdata_lsu_o,
  output logic                               load_err_o,
  output logic                               store_err_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                               busy_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  lsu_resp_meta_t  meta_q [MaxOutstanding];
  lsu_resp_meta_t  push_meta;
  lsu_resp_meta_t  head_meta;

  logic            push;
  logic            pop;
  logic            head_is_load;
  logic            head_is_store;
  logic [31:0]     fmt_rdata;

  assign busy_o        = (cnt_q != '0);
  assign pop           = data_rvalid_i & busy_o;
  assign req_ready_o   = (cnt_q != FullCnt) | pop;
  assign push          = req_valid_i & req_ready_o;
  assign outstanding_o = cnt_q;

  assign push_meta.instr_type = req_type_i;
  assign push_meta.size       = lsu_size_e'(req_size_i);
  assign push_meta.sign_ext   = req_sign_ext_i;
  assign push_meta.offset     = req_offset_i;

  // Explicit wrap keeps non-power-of-2 depths correct.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry contents are only meaningful while counted, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      meta_q[wr_ptr_q] <= push_meta;
    end
  end

  assign head_meta     = meta_q[rd_ptr_q];
  assign head_is_load  = (head_meta.instr_type == WB_INSTR_LOAD);
  assign head_is_store = (head_meta.instr_type == WB_INSTR_STORE);

  ibex_lsu_rdata_fmt u_rdata_fmt (
    .meta_i  (head_meta),
    .rdata_i (data_rdata_i),
    .rdata_o (fmt_rdata)
  );

  assign lsu_data_valid_o = pop;
  assign rf_we_lsu_o      = pop & head_is_load & ~data_err_i;
  assign load_err_o       = pop & head_is_load & data_err_i;
  assign store_err_o      = pop & head_is_store & data_err_i;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? fmt_rdata : 32'h0;

  a_completion_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({rf_we_lsu_o, load_err_o, store_err_o}));

  a_no_illegal_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_valid_i |-> req_ready_o)
    else $warning("lsu_resp_tracker: request dropped, queue full");

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> busy_o)
    else $warning("lsu_resp_tracker: response with no outstanding request ignored");

  a_legal_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (req_type_i != WB_INSTR_OTHER) && (req_size_i != 2'b11));

  a_half_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && req_size_i == 2'b01) |-> !req_offset_i[0]);

  a_word_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push && req_size_i == 2'b10) |-> (req_offset_i == 2'b00));

endmodule

// File: tb/tb_ibex_lsu_resp_tracker.sv
// Self-checking bench for ibex_lsu_resp_tracker: directed scenarios followed
// by random traffic, checked against a queue-based reference model.
module tb_ibex_lsu_resp_tracker;
  import ibex_lsu_resp_tracker_pkg::*;

  localparam int MAXO = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           req_valid_i = 1'b0;
  wb_instr_type_e req_type_i = WB_INSTR_LOAD;
  logic [1:0]     req_size_i = 2'b00;
  logic           req_sign_ext_i = 1'b0;
  logic [1:0]     req_offset_i = 2'b00;
  logic           req_ready_o;
  logic           data_rvalid_i = 1'b0;
  logic [31:0]    data_rdata_i = 32'h0;
  logic           data_err_i = 1'b0;
  logic           lsu_data_valid_o;
  logic           rf_we_lsu_o;
  logic [31:0]    rf_wdata_lsu_o;
  logic           load_err_o;
  logic           store_err_o;
  logic [1:0]     outstanding_o;
  logic           busy_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit     is_load;
    int     size;
    bit     sign_ext;
    int     offset;
  } req_t;

  req_t model_q[$];

  always #5 clk_i = ~clk_i;

  ibex_lsu_resp_tracker #(.MaxOutstanding(MAXO)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_type_i       (req_type_i),
    .req_size_i       (req_size_i),
    .req_sign_ext_i   (req_sign_ext_i),
    .req_offset_i     (req_offset_i),
    .req_ready_o      (req_ready_o),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .data_err_i       (data_err_i),
    .lsu_data_valid_o (lsu_data_valid_o),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o),
    .load_err_o       (load_err_o),
    .store_err_o      (store_err_o),
    .outstanding_o    (outstanding_o),
    .busy_o           (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected load value from the byte-lane rules, using plain arithmetic.
  function automatic logic [31:0] expect_load(input req_t r, input logic [31:0] rd);
    longint unsigned lane;
    longint v;
    lane = longint'(rd) / (longint'(1) << (8 * r.offset));
    if (r.size == 0) begin
      v = lane % 256;
      if (r.sign_ext && v >= 128) v = v - 256;
    end else if (r.size == 1) begin
      v = lane % 65536;
      if (r.sign_ext && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return v[31:0];
  endfunction

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // then advance the reference model on the clock edge.
  task automatic cyc(input string name, input bit pv, input bit ld, input int sz,
                     input bit se, input int off, input bit rv,
                     input logic [31:0] rd, input bit er);
    int     n;
    bit     exp_pop, exp_ready, exp_we, exp_lerr, exp_serr;
    logic [31:0] exp_wdata;
    req_t   r;
    req_valid_i    = pv;
    req_type_i     = ld ? WB_INSTR_LOAD : WB_INSTR_STORE;
    req_size_i     = 2'(sz);
    req_sign_ext_i = se;
    req_offset_i   = 2'(off);
    data_rvalid_i  = rv;
    data_rdata_i   = rd;
    data_err_i     = er;
    @(negedge clk_i);
    n         = model_q.size();
    exp_pop   = rv && (n > 0);
    exp_ready = (n < MAXO) || exp_pop;
    exp_we    = 0;
    exp_lerr  = 0;
    exp_serr  = 0;
    exp_wdata = 32'h0;
    if (exp_pop) begin
      exp_we    = model_q[0].is_load && !er;
      exp_lerr  = model_q[0].is_load && er;
      exp_serr  = !model_q[0].is_load && er;
      if (exp_we) exp_wdata = expect_load(model_q[0], rd);
    end
    chk({name, ".ready"},       32'(req_ready_o),      32'(exp_ready));
    chk({name, ".busy"},        32'(busy_o),           32'(n != 0));
    chk({name, ".outstanding"}, 32'(outstanding_o),    32'(n));
    chk({name, ".valid"},       32'(lsu_data_valid_o), 32'(exp_pop));
    chk({name, ".we"},          32'(rf_we_lsu_o),      32'(exp_we));
    chk({name, ".wdata"},       rf_wdata_lsu_o,        exp_wdata);
    chk({name, ".load_err"},    32'(load_err_o),       32'(exp_lerr));
    chk({name, ".store_err"},   32'(store_err_o),      32'(exp_serr));
    $display("txn %s push=%0d rvalid=%0d rdata=%08h err=%0d -> valid=%0d we=%0d wdata=%08h cnt=%0d",
             name, pv, rv, rd, er, lsu_data_valid_o, rf_we_lsu_o, rf_wdata_lsu_o, outstanding_o);
    @(posedge clk_i);
    if (exp_pop) void'(model_q.pop_front());
    if (pv && exp_ready) begin
      r.is_load  = ld;
      r.size     = sz;
      r.sign_ext = se;
      r.offset   = off;
      model_q.push_back(r);
    end
    #1;
    req_valid_i   = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.ready", 32'(req_ready_o), 32'd1);
    chk("rst.outstanding", 32'(outstanding_o), 32'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.valid", 32'(lsu_data_valid_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Signed byte load, offset 3
    cyc("sb_push", 1, 1, 0, 1, 3, 0, 32'h0, 0);
    cyc("sb_resp", 0, 1, 0, 0, 0, 1, 32'h80AA_BBCC, 0);
    cyc("sb_idle", 0, 1, 0, 0, 0, 0, 32'h0, 0);

    // Unsigned halfword load, offset 2
    cyc("uh_push", 1, 1, 1, 0, 2, 0, 32'h0, 0);
    cyc("uh_resp", 0, 1, 0, 0, 0, 1, 32'h8001_1234, 0);

    // Full queue with simultaneous push and pop
    cyc("full_p1", 1, 1, 2, 0, 0, 0, 32'h0, 0);
    cyc("full_p2", 1, 0, 2, 0, 0, 0, 32'h0, 0);
    cyc("full_hold", 0, 1, 0, 0, 0, 0, 32'h0, 0);
    cyc("full_pushpop", 1, 1, 0, 0, 1, 1, 32'h1122_3344, 0);
    cyc("full_store", 0, 1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    cyc("full_last", 0, 1, 0, 0, 0, 1, 32'h0000_5A00, 0);

    // Bus errors
    cyc("lerr_push", 1, 1, 2, 0, 0, 0, 32'h0, 0);
    cyc("lerr_resp", 0, 1, 0, 0, 0, 1, 32'hCAFE_F00D, 1);
    cyc("serr_push", 1, 0, 2, 0, 0, 0, 32'h0, 0);
    cyc("serr_resp", 0, 1, 0, 0, 0, 1, 32'hCAFE_F00D, 1);

    // Stray response, and one that arrives alongside a push
    cyc("stray", 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    cyc("stray_push", 1, 1, 2, 0, 0, 1, 32'h1234_5678, 0);
    cyc("stray_pair", 0, 1, 0, 0, 0, 1, 32'h8765_4321, 0);

    // Reset discards outstanding entries
    cyc("rst_p1", 1, 1, 2, 0, 0, 0, 32'h0, 0);
    cyc("rst_p2", 1, 1, 2, 0, 0, 0, 32'h0, 0);
    #1 rst_ni = 1'b0;
    model_q.delete();
    #1;
    chk("midrst.outstanding", 32'(outstanding_o), 32'd0);
    chk("midrst.busy", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cyc("post_rst", 0, 1, 0, 0, 0, 1, 32'hAAAA_5555, 0);

    // Pointer wrap through many sequential loads
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("wrap%0d_push", i), 1, 1, 2, 0, 0, 0, 32'h0, 0);
      cyc($sformatf("wrap%0d_resp", i), 0, 1, 0, 0, 0, 1, 32'(i), 0);
    end

    // Random legal traffic
    for (int i = 0; i < 300; i++) begin
      int  sz, off, n;
      bit  pv, rv;
      n   = model_q.size();
      rv  = (n > 0) && ($urandom_range(0, 2) != 0);
      pv  = ((n < MAXO) || rv) && ($urandom_range(0, 1) == 1);
      sz  = $urandom_range(0, 2);
      off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      cyc($sformatf("rnd%0d", i), pv, $urandom_range(0, 1), sz, $urandom_range(0, 1), off,
          rv, $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_lsu_resp_tracker.md
# ibex_lsu_resp_tracker

Data-bus response tracker for the load-store path. It records the metadata of every granted data-bus request in a small in-order queue and pairs each returning response with the request that caused it. It then formats load data (byte/halfword extraction, sign/zero extension) and drives the `lsu_data_valid`, `rf_we_lsu` and `rf_wdata_lsu` signals consumed by the writeback stage. It sits between the data-bus interface and `ibex_wb_stage`, and is the producer side of the writeback stage's load/store completion interface.

## Interface
- `MaxOutstanding`, default 2: queue depth, i.e. the maximum number of granted requests awaiting a response; legal values 1–4.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input 1: a data request is granted this cycle (`data_req & data_gnt`); push metadata.
- `req_type_i` input `wb_instr_type_e`: `WB_INSTR_LOAD` or `WB_INSTR_STORE`; `WB_INSTR_OTHER` is illegal.
- `req_size_i` input 2: 00 byte, 01 halfword, 10 word; 11 is illegal.
- `req_sign_ext_i` input 1: sign-extend load data (LB/LH).
- `req_offset_i` input 2: byte address bits [1:0].
- `req_ready_o` output 1: the queue can accept a push this cycle.
- `data_rvalid_i` input 1: bus response valid.
- `data_rdata_i` input 32: bus read data.
- `data_err_i` input 1: bus error, qualified by `data_rvalid_i`.
- `lsu_data_valid_o` output 1: head request completed this cycle.
- `rf_we_lsu_o` output 1: register-file write of load data.
- `rf_wdata_lsu_o` output 32: formatted load data.
- `load_err_o` output 1: load completed with a bus error.
- `store_err_o` output 1: store completed with a bus error.
- `outstanding_o` output `$clog2(MaxOutstanding+1)`: count of queued requests.
- `busy_o` output 1: `outstanding_o != 0`.

## Operation
- **Queue.** Circular FIFO of `MaxOutstanding` entries, each holding {type, size, sign_ext, offset}. The design uses a read pointer, a write pointer and a count. Pointers wrap modulo `MaxOutstanding`; for non-power-of-2 depths the wrap is explicit.
- **Push.** Occurs when `req_valid_i & req_ready_o`.
- **Pop.** Occurs when `data_rvalid_i & busy_o`.
- **Ready.** `req_ready_o = (count != MaxOutstanding) | (data_rvalid_i & busy_o)`. When the queue is full, a push and a pop in the same cycle are allowed.
- **Count update.** The count goes +1 on push only, −1 on pop only, and is unchanged on push plus pop.
- **Illegal push.** `req_valid_i` while `req_ready_o` is low is dropped and flagged by an assertion.
- **Completion outputs.** All are combinational from the head entry and the response, in the same cycle as `data_rvalid_i`:
  - `lsu_data_valid_o = data_rvalid_i & busy_o`.
  - `rf_we_lsu_o = lsu_data_valid_o & head.type==LOAD & ~data_err_i`.
  - `load_err_o = lsu_data_valid_o & head.type==LOAD & data_err_i`; `store_err_o` is the STORE equivalent.
- **Load formatting.** Shift `data_rdata_i` right by `8*offset`, then apply the size rule:
  - Byte: take bits [7:0]; extend bit 7 if sign_ext, otherwise zero-extend.
  - Halfword: take bits [15:0]; offset 0 or 2 only (offset 1 or 3 is illegal, asserted); extend bit 15.
  - Word: pass through unchanged; offset must be 0 (asserted).
- **Data gating.** `rf_wdata_lsu_o` is 0 whenever `rf_we_lsu_o` is low, so the writeback stage sees no X or stale data.
- **Stray response.** `data_rvalid_i` with the queue empty is ignored: no outputs pulse and the count stays 0. An assertion fires. A push in the same cycle does not pair with that response.
- **Reset.** Reset clears the pointers and count. Queue contents are not reset; they are don't-care while invalid.

## Timing
- Reset values: `req_ready_o`=1, `outstanding_o`=0, `busy_o`=0. All completion outputs are 0 because they are gated by `busy_o`.
- A response is paired at the earliest in the cycle after its push; there is no same-cycle bypass.
- Completion latency is zero cycles from `data_rvalid_i` to `lsu_data_valid_o` and `rf_we_lsu_o`.
- `outstanding_o` and `busy_o` are registered and update in the cycle after the push or pop.
- Responses are strictly in order; the block never reorders.
- Asserting reset mid-operation discards all outstanding entries. The first response after reset is treated as stray.

## Structure
- `ibex_pkg` additions: a `lsu_resp_meta_t` packed struct {type, size, sign_ext, offset}, and a `lsu_size_e` enum (`LSU_SIZE_B`, `LSU_SIZE_H`, `LSU_SIZE_W`). `wb_instr_type_e` is reused.
- One sub-module, `ibex_lsu_rdata_fmt`: purely combinational load formatting (shift, select, extend) from meta and rdata.
- Assertions use the existing `ASSERT` macros: onehot0 of {`rf_we_lsu_o`, `load_err_o`, `store_err_o`}, plus the illegal-push, stray-rvalid and alignment checks listed above.

## Test plan
- **Signed byte load.** Push LOAD/byte/sign/offset 3; next cycle rvalid with rdata 0x80AA_BBCC -> `rf_we_lsu_o`=1, `rf_wdata_lsu_o`=0xFFFF_FF80, `outstanding_o` returns to 0.
- **Unsigned halfword load.** Push LOAD/half/unsigned/offset 2; rdata 0x8001_1234 -> `rf_wdata_lsu_o`=0x0000_8001.
- **Back-to-back full queue.** `MaxOutstanding`=2. Push LOAD word, then STORE: count=2 and `req_ready_o`=0. In the next cycle apply rvalid together with `req_valid_i` -> `req_ready_o`=1, the pop and push both occur, and count stays 2. The second response yields `lsu_data_valid_o`=1 with `rf_we_lsu_o`=0.
- **Bus error.** Push LOAD word; rvalid with `data_err_i`=1 -> `load_err_o`=1, `rf_we_lsu_o`=0, `rf_wdata_lsu_o`=0. Repeat for STORE -> `store_err_o`=1.
- **Stray and reset.** rvalid with the queue empty -> all outputs stay 0 and the assertion fires. Push 2 entries, assert reset, release -> count=0; a following rvalid is ignored.
- **Pointer wrap.** Run 10 sequential single-request loads with words 0x0..0x9 -> returned data matches the push order, confirming pointer wrap-around.
